dht_poll_ctrl: RTL and testbench

DHT_POLL_CTRL -- requirements
Module: dht_poll_ctrl

---
 rtl/dht_pkg.sv | 14 +
 rtl/bin2bcd_seq.sv | 44 ++++
 rtl/dht_poll_ctrl.sv | 117 +++++++++++
 tb/tb_dht_poll_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/dht_pkg.sv
// Shared types and constants for the DHT poll controller and its BCD converters.
package dht_pkg;

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_CONV, S_HOLD} state_t;

  localparam int         BCD_W     = 8;
  localparam logic [7:0] CLAMP_MAX = 8'd99;

  // Two BCD digits cannot represent more than 99.
  function automatic logic [7:0] clamp_bin(input logic [7:0] b);
    return (b > CLAMP_MAX) ? CLAMP_MAX : b;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to two-digit BCD, one step per cycle, 8 steps.
module bin2bcd_seq
  import dht_pkg::*;
(
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             load,
  input  logic [7:0]       bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic [BCD_W+7:0] sh, sh_nxt;
  logic [3:0]       ones, tens;
  logic [2:0]       step;

  always_comb begin
    ones   = (sh[11:8]  >= 4'd5) ? sh[11:8]  + 4'd3 : sh[11:8];
    tens   = (sh[15:12] >= 4'd5) ? sh[15:12] + 4'd3 : sh[15:12];
    sh_nxt = {tens, ones, sh[7:0]} << 1;
  end

  // done flags the final step so the parent can register the result in the same edge.
  assign done = busy && (step == 3'd7);
  assign bcd  = sh_nxt[15:8];

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      sh   <= '0;
      step <= '0;
      busy <= 1'b0;
    end else if (load) begin
      sh   <= {8'h00, bin};
      step <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      sh   <= sh_nxt;
      step <= step + 3'd1;
      if (step == 3'd7) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/dht_poll_ctrl.sv
// Periodic DHT sensor poller: issues start pulses, times out missing frames,
// and converts the humidity/temperature integer bytes to BCD.
module dht_poll_ctrl
  import dht_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int POLL_MS    = 2000,
  parameter int TIMEOUT_MS = 50
)(
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEnable,
  input  logic             iDone,
  input  logic [7:0]       iHumid_Int,
  input  logic [7:0]       iTemp_Int,
  output logic             oStart,
  output logic [BCD_W-1:0] oHumid_BCD,
  output logic [BCD_W-1:0] oTemp_BCD,
  output logic             oValid,
  output logic             oErr,
  output logic             oUpdate
);

  localparam int DIV    = (CLK_FREQ / 1000 > 1) ? CLK_FREQ / 1000 : 1;
  localparam int DW     = $clog2(DIV + 1);
  localparam int MS_MAX = (POLL_MS > TIMEOUT_MS) ? POLL_MS : TIMEOUT_MS;
  localparam int MW     = $clog2(MS_MAX + 1) + 1;

  state_t           state;
  logic             en_q;
  logic [DW-1:0]    div_cnt;
  logic [MW-1:0]    ms_cnt;
  logic             ms_tick, tmo_hit, poll_hit, go_start, load, conv_busy;
  logic             h_busy, t_busy, h_done, t_done;
  logic [BCD_W-1:0] h_bcd, t_bcd;

  // "Reaching" N ms is the tick that takes the counter from N-1 to N.
  assign ms_tick   = (div_cnt == DW'(DIV - 1));
  assign tmo_hit   = ms_tick && (ms_cnt == MW'(TIMEOUT_MS - 1));
  assign poll_hit  = ms_tick && (ms_cnt == MW'(POLL_MS - 1));
  assign go_start  = ((state == S_IDLE) && en_q) ||
                     ((state == S_HOLD) && poll_hit && iEnable);
  assign conv_busy = h_busy | t_busy;
  assign load      = (state == S_WAIT) && iDone && !conv_busy;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst)                   div_cnt <= '0;
    else if (go_start || ms_tick) div_cnt <= '0;
    else                         div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst)                              ms_cnt <= '0;
    else if (state == S_START)              ms_cnt <= '0;
    else if (ms_tick && (ms_cnt != '1))     ms_cnt <= ms_cnt + 1'b1;
  end

  bin2bcd_seq u_humid (
    .gclk(iClk), .grst_n(iRst), .load(load), .bin(clamp_bin(iHumid_Int)),
    .busy(h_busy), .done(h_done), .bcd(h_bcd)
  );

  bin2bcd_seq u_temp (
    .gclk(iClk), .grst_n(iRst), .load(load), .bin(clamp_bin(iTemp_Int)),
    .busy(t_busy), .done(t_done), .bcd(t_bcd)
  );

  // en_q delays the first start after reset by one sampling edge.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state      <= S_IDLE;
      en_q       <= 1'b0;
      oStart     <= 1'b0;
      oUpdate    <= 1'b0;
      oValid     <= 1'b0;
      oErr       <= 1'b0;
      oHumid_BCD <= '0;
      oTemp_BCD  <= '0;
    end else begin
      en_q    <= iEnable;
      oStart  <= 1'b0;
      oUpdate <= 1'b0;
      case (state)
        S_IDLE: if (go_start) begin
          state  <= S_START;
          oStart <= 1'b1;
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (load) state <= S_CONV;
          else if (tmo_hit) begin
            state <= S_HOLD;
            oErr  <= 1'b1;
          end
        end
        S_CONV: if (h_done && t_done) begin
          oHumid_BCD <= h_bcd;
          oTemp_BCD  <= t_bcd;
          oUpdate    <= 1'b1;
          oValid     <= 1'b1;
          oErr       <= 1'b0;
          state      <= S_HOLD;
        end
        S_HOLD: if (poll_hit) begin
          if (go_start) begin
            state  <= S_START;
            oStart <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dht_poll_ctrl.sv
// Self-checking bench for dht_poll_ctrl at 10 cycles/ms, 20 ms poll, 5 ms timeout.
module tb_dht_poll_ctrl;

  logic       iClk = 1'b0, iRst = 1'b0, iEnable = 1'b0, iDone = 1'b0;
  logic [7:0] iHumid_Int = '0, iTemp_Int = '0;
  logic       oStart, oValid, oErr, oUpdate;
  logic [7:0] oHumid_BCD, oTemp_BCD;

  always #5 iClk = ~iClk;

  dht_poll_ctrl #(.CLK_FREQ(10_000), .POLL_MS(20), .TIMEOUT_MS(5)) dut (
    .iClk(iClk), .iRst(iRst), .iEnable(iEnable), .iDone(iDone),
    .iHumid_Int(iHumid_Int), .iTemp_Int(iTemp_Int),
    .oStart(oStart), .oHumid_BCD(oHumid_BCD), .oTemp_BCD(oTemp_BCD),
    .oValid(oValid), .oErr(oErr), .oUpdate(oUpdate)
  );

  int n_vec = 0, n_err = 0;

  // Reference state: last good reading and status flags.
  logic [7:0] m_h = '0, m_t = '0;
  logic       m_valid = 1'b0, m_err = 1'b0;

  typedef struct {
    logic [7:0] h, t;
    int         d;       // iDone cycle offset from the oStart cycle
    logic [7:0] eh, et;  // expected BCD when the frame is accepted
    logic       err;     // expected oErr after the poll
  } vec_t;

  function automatic logic [7:0] ref_bcd(input int x);
    int v;
    v = (x > 99) ? 99 : x;
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  // Entered on the sample where oStart is high; leaves on the sample 200 cycles later.
  task automatic run_poll(input logic [7:0] h, input logic [7:0] t, input int d,
                          input logic [7:0] eh, input logic [7:0] et, input bit drop_en);
    bit ok;
    int spur;
    ok   = (d >= 1) && (d <= 49);
    spur = 0;
    iHumid_Int = h;
    iTemp_Int  = t;
    for (int c = 0; c < 200; c++) begin
      if (oStart !== (c == 0)) spur++;
      if (oUpdate !== (ok && (c == d + 9))) spur++;
      if (ok && (c == d + 9)) begin
        chk("humid_bcd", oHumid_BCD, eh);
        chk("temp_bcd", oTemp_BCD, et);
        chk("valid_after_update", oValid, 1);
        chk("err_after_update", oErr, 0);
        m_h = eh; m_t = et; m_valid = 1'b1; m_err = 1'b0;
      end
      if (!ok && (c == 50)) begin
        chk("err_on_timeout", oErr, 1);
        chk("humid_kept_on_timeout", oHumid_BCD, m_h);
        chk("temp_kept_on_timeout", oTemp_BCD, m_t);
        chk("valid_kept_on_timeout", oValid, m_valid);
        m_err = 1'b1;
      end
      iDone = (c == d);
      if (drop_en && (c == d + 3)) iEnable = 1'b0;
      step();
    end
    iDone = 1'b0;
    chk("spurious_pulses", spur, 0);
    chk("next_start_at_200", oStart, !drop_en);
  endtask

  vec_t tbl[9];

  initial begin
    int k, bad;
    logic [7:0] rh, rt;
    int rd;

    tbl[0] = '{8'd45,  8'd27,  30, 8'h45, 8'h27, 1'b0};
    tbl[1] = '{8'd0,   8'd0,   99, 8'h00, 8'h00, 1'b1};
    tbl[2] = '{8'd120, 8'd0,   10, 8'h99, 8'h00, 1'b0};
    tbl[3] = '{8'd200, 8'd9,   49, 8'h99, 8'h09, 1'b0};
    tbl[4] = '{8'd55,  8'd66,  50, 8'h00, 8'h00, 1'b1};
    tbl[5] = '{8'd99,  8'd100, 1,  8'h99, 8'h99, 1'b0};
    tbl[6] = '{8'd10,  8'd5,   0,  8'h00, 8'h00, 1'b1};
    tbl[7] = '{8'd9,   8'd90,  5,  8'h09, 8'h90, 1'b0};
    tbl[8] = '{8'd255, 8'd98,  20, 8'h99, 8'h98, 1'b0};

    // Held in reset with enable high: nothing may move.
    iEnable = 1'b1;
    repeat (3) step();
    chk("rst_start", oStart, 0);
    chk("rst_update", oUpdate, 0);
    chk("rst_valid", oValid, 0);
    chk("rst_err", oErr, 0);
    chk("rst_humid", oHumid_BCD, 0);
    chk("rst_temp", oTemp_BCD, 0);

    iRst = 1'b1;
    step();
    chk("start_after_1_edge", oStart, 0);
    step();
    chk("start_after_2_edges", oStart, 1);

    for (int i = 0; i < 9; i++) begin
      run_poll(tbl[i].h, tbl[i].t, tbl[i].d, tbl[i].eh, tbl[i].et, 1'b0);
      chk("tbl_err", oErr, tbl[i].err);
    end

    for (int i = 0; i < 10; i++) begin
      rh = 8'($urandom_range(0, 255));
      rt = 8'($urandom_range(0, 255));
      rd = $urandom_range(0, 60);
      run_poll(rh, rt, rd, ref_bcd(rh), ref_bcd(rt), 1'b0);
      chk("rand_err", oErr, m_err);
    end

    // Enable dropped mid-conversion: update still lands, then polling stops.
    run_poll(8'd61, 8'd3, 20, 8'h61, 8'h03, 1'b1);
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      if (oStart !== 1'b0) bad++;
      step();
    end
    chk("no_start_when_disabled", bad, 0);

    iEnable = 1'b1;
    k = 0;
    while (k < 10) begin
      step();
      k++;
      if (oStart === 1'b1) break;
    end
    chk("restart_latency", k, 2);

    // Reset in the middle of a conversion.
    iHumid_Int = 8'd33;
    iTemp_Int  = 8'd44;
    for (int c = 0; c < 8; c++) begin
      iDone = (c == 5);
      step();
    end
    iDone = 1'b0;
    iRst  = 1'b0;
    #1;
    chk("midrst_valid", oValid, 0);
    chk("midrst_err", oErr, 0);
    chk("midrst_humid", oHumid_BCD, 0);
    chk("midrst_temp", oTemp_BCD, 0);
    chk("midrst_update", oUpdate, 0);
    chk("midrst_start", oStart, 0);
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (oUpdate !== 1'b0 || oStart !== 1'b0 || oValid !== 1'b0) bad++;
    end
    chk("midrst_quiet", bad, 0);
    iRst = 1'b1;
    m_h = '0; m_t = '0; m_valid = 1'b0; m_err = 1'b0;
    step();
    chk("rel_start_edge1", oStart, 0);
    step();
    chk("rel_start_edge2", oStart, 1);
    run_poll(8'd7, 8'd88, 12, 8'h07, 8'h88, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
